// File: rtl/zrle_comp.sv
// zrle_comp: zero-lane run-length encoder. Classifies 16-bit lanes, emits variable-length codes packed MSB-first into 64-bit burst words.
// Optional ZRLE_COMP_STATS_EN adds comp_bits_o (encoded bits of the last burst, header included, padding excluded).
module zrle_comp #(
  parameter int BURST_WORDS   = 16,
  parameter int MAX_OUT_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [63:0] data_i,
  input  logic        sop_i,
  input  logic        eop_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [63:0] data_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic        ovf_o,
`ifdef ZRLE_COMP_STATS_EN
  output logic [10:0] comp_bits_o,
`endif
  input  logic        ready_i
);

  localparam int ACC_W = 130;
  localparam int IN_CW = $clog2(BURST_WORDS + 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [IN_CW-1:0] in_cnt_q, in_cnt_d;
  logic [4:0]       out_cnt_q, out_cnt_d;
  logic             valid_q, valid_d;
  logic [63:0]      data_q, data_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             ovf_q, ovf_d;

  logic [15:0] l0, l1, l2, l3;
  logic [3:0]  nz;
  logic [65:0] code;
  logic [6:0]  code_len;
  logic        hdr;
  logic [67:0] ins;
  logic [7:0]  ins_len;
  logic        accept, emit, last_emit;

  // Bursts always start at the first word after the previous burst ended, so sop_i adds no information.
  logic unused_sop;
  assign unused_sop = sop_i;

  assign l0 = data_i[15:0];
  assign l1 = data_i[31:16];
  assign l2 = data_i[47:32];
  assign l3 = data_i[63:48];
  assign nz = {|l3, |l2, |l1, |l0};

  // Codes are built left-aligned in 66 bits; the tail past code_len stays zero.
  always_comb begin
    code     = '0;
    code_len = 7'd6;
    case (nz)
      4'b0001: begin code = {6'b000001, l0, 44'b0};     code_len = 7'd22; end
      4'b0010: begin code = {5'b00001, l1, 45'b0};      code_len = 7'd21; end
      4'b0100: begin code = {5'b00010, l2, 45'b0};      code_len = 7'd21; end
      4'b1000: begin code = {5'b00011, l3, 45'b0};      code_len = 7'd21; end
      4'b0011: begin code = {4'b0010, l1, l0, 30'b0};   code_len = 7'd36; end
      4'b0101: begin code = {4'b0011, l2, l0, 30'b0};   code_len = 7'd36; end
      4'b1001: begin code = {4'b0100, l3, l0, 30'b0};   code_len = 7'd36; end
      4'b0110: begin code = {4'b0101, l2, l1, 30'b0};   code_len = 7'd36; end
      4'b1010: begin code = {4'b0110, l3, l1, 30'b0};   code_len = 7'd36; end
      4'b1100: begin code = {4'b0111, l3, l2, 30'b0};   code_len = 7'd36; end
      4'b0111: begin code = {4'b1000, l2, l1, l0, 14'b0}; code_len = 7'd52; end
      4'b1011: begin code = {4'b1001, l3, l1, l0, 14'b0}; code_len = 7'd52; end
      4'b1101: begin code = {4'b1010, l3, l2, l0, 14'b0}; code_len = 7'd52; end
      4'b1110: begin code = {4'b1011, l3, l2, l1, 14'b0}; code_len = 7'd52; end
      4'b1111: begin code = {2'b11, data_i};            code_len = 7'd66; end
      default: begin code = '0;                          code_len = 7'd6;  end
    endcase
  end

  assign hdr     = (in_cnt_q == '0);
  assign ins     = hdr ? {2'b00, code} : {code, 2'b00};
  assign ins_len = {1'b0, code_len} + (hdr ? 8'd2 : 8'd0);

  assign ready_o   = (cnt_q < 8'd64) && !flush_q;
  assign accept    = valid_i && ready_o;
  assign emit      = (!valid_q || ready_i) && ((cnt_q >= 8'd64) || (flush_q && (cnt_q != 8'd0)));
  assign last_emit = emit && flush_q && (cnt_q <= 8'd64);

  // Accept and emit are mutually exclusive: accepting needs cnt<64 and no flush, emitting needs the opposite.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    ovf_d     = ovf_q;
    if (accept) begin
      acc_d    = acc_q | ({ins, 62'b0} >> cnt_q);
      cnt_d    = cnt_q + ins_len;
      in_cnt_d = in_cnt_q + IN_CW'(1);
      if (eop_i || (in_cnt_q == IN_CW'(BURST_WORDS - 1))) flush_d = 1'b1;
    end else if (emit) begin
      acc_d     = acc_q << 64;
      cnt_d     = (cnt_q >= 8'd64) ? (cnt_q - 8'd64) : 8'd0;
      out_cnt_d = last_emit ? 5'd0 : (out_cnt_q + 5'd1);
      if (last_emit) begin
        flush_d  = 1'b0;
        in_cnt_d = '0;
      end
    end
    if (emit) begin
      valid_d = 1'b1;
      data_d  = acc_q[ACC_W-1:ACC_W-64];
      sop_d   = (out_cnt_q == 5'd0);
      eop_d   = last_emit;
      ovf_d   = last_emit && ((int'(out_cnt_q) + 1) > MAX_OUT_WORDS);
    end else if (ready_i) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      ovf_q     <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign ovf_o   = ovf_q;

`ifdef ZRLE_COMP_STATS_EN
  logic [10:0] bits_q, bits_d, hold_q, hold_d, comp_bits_q, comp_bits_d;

  // The total is parked in hold_q at the last emit because the next burst may start before eop_o is taken.
  always_comb begin
    bits_d      = bits_q;
    hold_d      = hold_q;
    comp_bits_d = comp_bits_q;
    if (accept) bits_d = bits_q + {3'b000, ins_len};
    if (last_emit) begin
      hold_d = bits_q;
      bits_d = '0;
    end
    if (valid_q && ready_i && eop_q) comp_bits_d = hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q      <= '0;
      hold_q      <= '0;
      comp_bits_q <= '0;
    end else begin
      bits_q      <= bits_d;
      hold_q      <= hold_d;
      comp_bits_q <= comp_bits_d;
    end
  end

  assign comp_bits_o = comp_bits_q;
`endif

endmodule

// File: tb/tb_zrle_comp.sv
// Testbench for zrle_comp: directed and randomized bursts checked against a bit-queue encoder model
// and a decoder round trip of the received stream.
module tb_zrle_comp;
  localparam int MAX_OUT = 8;
  typedef struct packed { logic [63:0] d; logic s; logic e; logic o; } ow_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, sop_i = 1'b0, eop_i = 1'b0, ready_i = 1'b1;
  logic [63:0] data_i = '0;
  logic        ready_o, valid_o, sop_o, eop_o, ovf_o;
  logic [63:0] data_o;
`ifdef ZRLE_COMP_STATS_EN
  logic [10:0] comp_bits_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;
  int pos;
  logic [63:0] in_w[$];
  bit exp_bits[$];
  bit rx_bits[$];
  ow_t exp_q[$];
  ow_t got_q[$];

  always #5 clk = ~clk;

  zrle_comp dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o), .ovf_o(ovf_o),
`ifdef ZRLE_COMP_STATS_EN
    .comp_bits_o(comp_bits_o),
`endif
    .ready_i(ready_i)
  );

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: ready_i = 1'b1;
      1: ready_i = ($urandom_range(0, 2) != 0);
      default: ready_i = 1'b0;
    endcase
  end

  always @(negedge clk)
    if (rst_n && valid_o && ready_i) got_q.push_back(ow_t'({data_o, sop_o, eop_o, ovf_o}));

  function automatic void push_val(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) exp_bits.push_back(v[i]);
  endfunction

  // Reference encoder: a flat bit list per burst, padded and cut into 64-bit words.
  function automatic void model_burst();
    int n;
    exp_bits.delete();
    exp_q.delete();
    push_val(64'd0, 2);
    foreach (in_w[j]) begin
      logic [15:0] ln[4];
      int cnt_nz, z, hi, lo;
      cnt_nz = 0; z = 0; hi = -1; lo = -1;
      for (int k = 0; k < 4; k++) begin
        ln[k] = in_w[j][16*k +: 16];
        if (ln[k] != 0) begin
          cnt_nz++;
          if (lo < 0) lo = k;
          hi = k;
        end else z = k;
      end
      case (cnt_nz)
        0: push_val(64'd0, 6);
        1: begin
          if (lo == 0) push_val(64'd1, 6); else push_val(64'(lo), 5);
          push_val(64'(ln[lo]), 16);
        end
        2: begin
          push_val((lo == 0) ? 64'(1 + hi) : (lo == 1) ? 64'(3 + hi) : 64'd7, 4);
          push_val(64'(ln[hi]), 16);
          push_val(64'(ln[lo]), 16);
        end
        3: begin
          push_val(64'(8 + 3 - z), 4);
          for (int k = 3; k >= 0; k--) if (k != z) push_val(64'(ln[k]), 16);
        end
        default: begin
          push_val(64'd3, 2);
          push_val(in_w[j], 64);
        end
      endcase
    end
    while (exp_bits.size() % 64 != 0) exp_bits.push_back(1'b0);
    n = exp_bits.size() / 64;
    for (int i = 0; i < n; i++) begin
      logic [63:0] w;
      for (int b = 0; b < 64; b++) w[63-b] = exp_bits[64*i + b];
      exp_q.push_back(ow_t'({w, i == 0, i == n - 1, (i == n - 1) && (n > MAX_OUT)}));
    end
  endfunction

  function automatic logic [63:0] rd(input int w);
    logic [63:0] v = '0;
    for (int i = 0; i < w; i++) begin
      v = {v[62:0], (pos < rx_bits.size()) ? rx_bits[pos] : 1'b0};
      pos++;
    end
    return v;
  endfunction

  // Independent decoder walking the prefix tree of the code table.
  function automatic logic [63:0] dec_word();
    logic [63:0] v = '0;
    int t, z, hi, lo;
    t = int'(rd(2));
    if (t == 3) return rd(64);
    if (t == 2) begin
      z = 3 - int'(rd(2));
      for (int k = 3; k >= 0; k--) if (k != z) v[16*k +: 16] = rd(16)[15:0];
      return v;
    end
    if (t == 1) begin
      t = int'(rd(2));
      case (t)
        0: begin hi = 3; lo = 0; end
        1: begin hi = 2; lo = 1; end
        2: begin hi = 3; lo = 1; end
        default: begin hi = 3; lo = 2; end
      endcase
      v[16*hi +: 16] = rd(16)[15:0];
      v[16*lo +: 16] = rd(16)[15:0];
      return v;
    end
    t = int'(rd(2));
    if (t >= 2) begin
      hi = (t == 2) ? 1 : 2;
      v[16*hi +: 16] = rd(16)[15:0];
      v[15:0] = rd(16)[15:0];
    end else if (t == 1) begin
      hi = (rd(1) != 0) ? 3 : 2;
      v[16*hi +: 16] = rd(16)[15:0];
    end else if (rd(1) != 0) begin
      v[31:16] = rd(16)[15:0];
    end else if (rd(1) != 0) begin
      v[15:0] = rd(16)[15:0];
    end
    return v;
  endfunction

  function automatic logic [63:0] rand_word(input bit dense);
    logic [63:0] w = '0;
    for (int k = 0; k < 4; k++)
      if (dense || ($urandom_range(0, 1) != 0)) w[16*k +: 16] = 16'($urandom_range(1, 65535));
    return w;
  endfunction

  task automatic run_burst(input bit use_eop, input bit gaps);
    int guard;
    @(posedge clk); #1;
    for (int i = 0; i < in_w.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        valid_i = 1'b0;
        @(posedge clk); #1;
      end
      valid_i = 1'b1;
      data_i  = in_w[i];
      sop_i   = (i == 0) || (gaps && ($urandom_range(0, 7) == 0));
      eop_i   = use_eop && (i == in_w.size() - 1);
      guard = 0;
      @(negedge clk);
      while (!ready_o && guard < 500) begin @(negedge clk); guard++; end
      if (guard >= 500) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout word %0d: ready_o=%b, required 1", i, ready_o);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0;
  endtask

  task automatic wait_eop();
    int guard = 0;
    while (!(got_q.size() > 0 && got_q[got_q.size()-1].e) && guard < 4000) begin
      @(posedge clk); guard++;
    end
    if (guard >= 4000) begin
      vectors++; miscompares++;
      $display("FAIL eop_timeout: got %0d words without eop_o", got_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({valid_o, sop_o, eop_o, ovf_o, data_o} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: v/s/e/o/data=%b%b%b%b %h, required all 0", valid_o, sop_o, eop_o, ovf_o, data_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: ready_o=%b, required 1", ready_o); end
    vectors++;
    if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: valid_o=%b, required 0", valid_o); end
  endtask

  task automatic test_zero_burst();
    in_w.delete();
    repeat (16) in_w.push_back(64'd0);
    got_q.delete();
    run_burst(1'b0, 1'b0);
    wait_eop();
    vectors++;
    if (got_q.size() != 2) begin miscompares++; $display("FAIL zero_count: got %0d words, required 2", got_q.size()); end
    if (got_q.size() == 2) begin
      vectors++;
      if (got_q[0] !== ow_t'({64'd0, 1'b1, 1'b0, 1'b0})) begin
        miscompares++; $display("FAIL zero_word0: got %h, required %h", got_q[0], ow_t'({64'd0, 3'b100}));
      end
      vectors++;
      if (got_q[1] !== ow_t'({64'd0, 1'b0, 1'b1, 1'b0})) begin
        miscompares++; $display("FAIL zero_word1: got %h, required %h", got_q[1], ow_t'({64'd0, 3'b010}));
      end
    end
  endtask

  task automatic test_one_lane();
    in_w.delete();
    in_w.push_back(64'h0000_0000_0000_ABCD);
    repeat (15) in_w.push_back(64'd0);
    got_q.delete();
    run_burst(1'b1, 1'b0);
    wait_eop();
    vectors++;
    if (got_q.size() != 2) begin miscompares++; $display("FAIL one_lane_count: got %0d, required 2", got_q.size()); end
    if (got_q.size() == 2) begin
      vectors++;
      if (got_q[0] !== ow_t'({64'h01ABCD0000000000, 3'b100})) begin
        miscompares++; $display("FAIL one_lane_word0: got %h, required %h", got_q[0], ow_t'({64'h01ABCD0000000000, 3'b100}));
      end
      vectors++;
      if (got_q[1] !== ow_t'({64'd0, 3'b010})) begin
        miscompares++; $display("FAIL one_lane_word1: got %h, required %h", got_q[1], ow_t'({64'd0, 3'b010}));
      end
    end
  endtask

  task automatic test_two_lane_exact();
    in_w.delete();
    in_w.push_back(64'h0000_1111_0000_2222);
    repeat (15) in_w.push_back(64'd0);
    got_q.delete();
    run_burst(1'b1, 1'b0);
    wait_eop();
    vectors++;
    if (got_q.size() != 2) begin miscompares++; $display("FAIL two_lane_count: got %0d, required 2", got_q.size()); end
    if (got_q.size() == 2) begin
      vectors++;
      if (got_q[0] !== ow_t'({64'h0C44448888000000, 3'b100})) begin
        miscompares++; $display("FAIL two_lane_word0: got %h, required %h", got_q[0], ow_t'({64'h0C44448888000000, 3'b100}));
      end
      vectors++;
      if (got_q[1] !== ow_t'({64'd0, 3'b010})) begin
        miscompares++; $display("FAIL two_lane_word1: got %h, required %h", got_q[1], ow_t'({64'd0, 3'b010}));
      end
    end
  endtask

  task automatic test_all_nonzero();
    logic [63:0] dw;
    in_w.delete();
    repeat (16) in_w.push_back(rand_word(1'b1));
    model_burst();
    got_q.delete();
    run_burst(1'b0, 1'b0);
    wait_eop();
    vectors++;
    if (got_q.size() != 17) begin miscompares++; $display("FAIL dense_count: got %0d, required 17", got_q.size()); end
    if (got_q.size() == 17) begin
      vectors++;
      if ({got_q[16].e, got_q[16].o, got_q[15].e} !== 3'b110) begin
        miscompares++; $display("FAIL dense_flags: eop16/ovf16/eop15=%b%b%b, required 110", got_q[16].e, got_q[16].o, got_q[15].e);
      end
      for (int i = 0; i < 17; i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL dense_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
      end
    end
    rx_bits.delete();
    foreach (got_q[i]) for (int b = 63; b >= 0; b--) rx_bits.push_back(got_q[i].d[b]);
    pos = 2;
    foreach (in_w[j]) begin
      dw = dec_word();
      vectors++;
      if (dw !== in_w[j]) begin miscompares++; $display("FAIL dense_roundtrip%0d: got %h, required %h", j, dw, in_w[j]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] dw;
    int n;
    bit use_eop;
    rdy_mode = 1;
    for (int burst = 0; burst < 25; burst++) begin
      n = $urandom_range(1, 16);
      use_eop = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      in_w.delete();
      for (int i = 0; i < n; i++) in_w.push_back(($urandom_range(0, 4) == 0) ? 64'd0 : rand_word(1'($urandom_range(0, 3) == 0)));
      model_burst();
      got_q.delete();
      run_burst(use_eop, 1'b1);
      wait_eop();
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL rand_count burst %0d: got %0d, required %0d", burst, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand_word burst %0d idx %0d: got %h, required %h", burst, i, got_q[i], exp_q[i]);
        end
      end
      rx_bits.delete();
      foreach (got_q[i]) for (int b = 63; b >= 0; b--) rx_bits.push_back(got_q[i].d[b]);
      pos = 2;
      foreach (in_w[j]) begin
        dw = dec_word();
        vectors++;
        if (dw !== in_w[j]) begin miscompares++; $display("FAIL rand_roundtrip burst %0d idx %0d: got %h, required %h", burst, j, dw, in_w[j]); end
      end
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [63:0] dw;
    logic [65:0] snap;
    int guard;
    in_w.delete();
    repeat (16) in_w.push_back(rand_word(1'b1));
    model_burst();
    got_q.delete();
    rdy_mode = 0;
    fork
      run_burst(1'b1, 1'b0);
      begin
        guard = 0;
        @(negedge clk);
        while (!valid_o && guard < 500) begin @(negedge clk); guard++; end
        rdy_mode = 2;
        @(posedge clk); #2;
        @(negedge clk);
        while (!valid_o && guard < 1000) begin @(negedge clk); guard++; end
        vectors++;
        if (guard >= 1000) begin miscompares++; $display("FAIL stall_valid_timeout: valid_o=%b, required 1", valid_o); end
        snap = {data_o, sop_o, eop_o};
        repeat (5) begin
          @(negedge clk);
          vectors++;
          if ({valid_o, data_o, sop_o, eop_o} !== {1'b1, snap}) begin
            miscompares++; $display("FAIL stall_hold: got %h, required %h", {valid_o, data_o, sop_o, eop_o}, {1'b1, snap});
          end
        end
        vectors++;
        if (ready_o !== 1'b0) begin miscompares++; $display("FAIL stall_ready: ready_o=%b, required 0", ready_o); end
        rdy_mode = 0;
      end
    join
    wait_eop();
    vectors++;
    if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL stall_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stall_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    rx_bits.delete();
    foreach (got_q[i]) for (int b = 63; b >= 0; b--) rx_bits.push_back(got_q[i].d[b]);
    pos = 2;
    foreach (in_w[j]) begin
      dw = dec_word();
      vectors++;
      if (dw !== in_w[j]) begin miscompares++; $display("FAIL stall_roundtrip%0d: got %h, required %h", j, dw, in_w[j]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    rdy_mode = 0;
    in_w.delete();
    repeat (6) in_w.push_back(rand_word(1'b1));
    run_burst(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({valid_o, sop_o, eop_o, ovf_o, data_o} !== 68'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs: v/s/e/o/data=%b%b%b%b %h, required all 0", valid_o, sop_o, eop_o, ovf_o, data_o);
    end
    vectors++;
    if (ready_o !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: ready_o=%b, required 1", ready_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_zero_burst();
  endtask

  initial begin
    test_reset();
    test_zero_burst();
    test_one_lane();
    test_two_lane_exact();
    test_all_nonzero();
    test_random();
    test_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
